// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART TX arbiter: FSM encoding, flag polarity, widths.
package uart_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_BUSY = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_ACK       = 2'd3
  } arb_state_t;

  localparam int unsigned DEFAULT_TIMEOUT = 16;
  localparam int unsigned ID_W            = 3;
  localparam int unsigned BYTE_W          = 8;

  // txd_flag polarity from uart_txd: low while a frame is on the line
  localparam logic FLAG_BUSY = 1'b0;
  localparam logic FLAG_IDLE = 1'b1;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first active request after `last`, wrapping.
module uart_rr_pick
  import uart_tx_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ = 4
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  last,
  output logic [ID_W-1:0]  winner,
  output logic             valid
);

  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  // Walk offsets from farthest to nearest so the nearest active request wins
  always_comb begin
    int idx;
    winner = last;
    valid  = 1'b0;
    idx    = 0;
    for (int off = int'(N_REQ); off >= 1; off--) begin
      idx = int'(last) + off;
      if (idx >= int'(N_REQ)) idx = idx - int'(N_REQ);
      if (req[IDX_W'(idx)]) begin
        winner = ID_W'(idx);
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_txd between N_REQ byte sources, one byte per grant.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                    clk50M,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req,
  input  logic [BYTE_W*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]        ack,
  output logic [ID_W-1:0]         grant_id,
  output logic                    busy,
  output logic                    timeout_err,
  output logic                    txd_cmd,
  output logic [BYTE_W-1:0]       txd_data,
  input  logic                    txd_flag
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  arb_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ID_W-1:0]   last_q, last_d;
  logic [N_REQ-1:0]  ack_d;
  logic [ID_W-1:0]   grant_d;
  logic              busy_d;
  logic              terr_d;
  logic              cmd_d;
  logic [BYTE_W-1:0] data_d;

  logic [ID_W-1:0]   pick_winner;
  logic              pick_valid;
  logic [N_REQ-1:0]  grant_oh;
  logic [BYTE_W-1:0] pick_data;

  uart_rr_pick #(
    .N_REQ (N_REQ)
  ) u_pick (
    .req    (req),
    .last   (last_q),
    .winner (pick_winner),
    .valid  (pick_valid)
  );

  // Winner's byte slice and the one-hot form of the current grant
  always_comb begin
    pick_data = '0;
    grant_oh  = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (pick_winner == ID_W'(i)) pick_data = req_data[i*BYTE_W +: BYTE_W];
      grant_oh[i] = (grant_id == ID_W'(i));
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    ack_d   = '0;
    grant_d = grant_id;
    busy_d  = busy;
    terr_d  = timeout_err;
    cmd_d   = 1'b0;
    data_d  = txd_data;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          grant_d = pick_winner;
          data_d  = pick_data;
          cmd_d   = 1'b1;
          busy_d  = 1'b1;
          last_d  = pick_winner;
          cnt_d   = '0;
          state_d = ST_WAIT_BUSY;
        end
      end
      ST_WAIT_BUSY: begin
        if (txd_flag == FLAG_BUSY) begin
          state_d = ST_WAIT_DONE;
        end else if (cnt_q == CNT_W'(TIMEOUT)) begin
          terr_d  = 1'b1;
          ack_d   = grant_oh;
          state_d = ST_ACK;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_WAIT_DONE: begin
        // Frame length bounds this wait, so no timeout here
        if (txd_flag == FLAG_IDLE) begin
          ack_d   = grant_oh;
          state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk50M or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      last_q      <= ID_W'(N_REQ - 1);
      ack         <= '0;
      grant_id    <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      txd_cmd     <= 1'b0;
      txd_data    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      ack         <= ack_d;
      grant_id    <= grant_d;
      busy        <= busy_d;
      timeout_err <= terr_d;
      txd_cmd     <= cmd_d;
      txd_data    <= data_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a behavioural uart_txd flag model.
module tb_uart_tx_arbiter;

  localparam int unsigned N      = 4;
  localparam int unsigned TO     = 16;
  localparam int          HOLD   = 20;
  localparam int          LAT_OK = HOLD + 3;
  localparam int          LAT_TO = int'(TO) + 1;

  logic           clk50M;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   ack;
  logic [2:0]     grant_id;
  logic           busy;
  logic           timeout_err;
  logic           txd_cmd;
  logic [7:0]     txd_data;
  logic           txd_flag;

  typedef struct packed {
    logic [2:0] id;
    logic [7:0] data;
  } grant_exp_t;

  typedef struct packed {
    logic [N-1:0] mask;
    logic         terr;
    logic [7:0]   lat;
  } ack_exp_t;

  grant_exp_t exp_g[$];
  ack_exp_t   exp_a[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         remaining[N];
  logic       never_drop = 1'b0;

  uart_tx_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
    .clk50M      (clk50M),
    .rst_n       (rst_n),
    .req         (req),
    .req_data    (req_data),
    .ack         (ack),
    .grant_id    (grant_id),
    .busy        (busy),
    .timeout_err (timeout_err),
    .txd_cmd     (txd_cmd),
    .txd_data    (txd_data),
    .txd_flag    (txd_flag)
  );

  initial begin
    clk50M = 1'b0;
    forever #10 clk50M = ~clk50M;
  end

  always @(posedge clk50M) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_grant(input int id, input logic [7:0] data);
    grant_exp_t g;
    g.id   = 3'(id);
    g.data = data;
    exp_g.push_back(g);
  endtask

  task automatic push_ack(input logic [N-1:0] mask, input logic terr, input int lat);
    ack_exp_t a;
    a.mask = mask;
    a.terr = terr;
    a.lat  = 8'(lat);
    exp_a.push_back(a);
  endtask

  // uart_txd model: flag drops 2 cycles after cmd, stays low HOLD cycles
  initial begin
    int mphase;
    int mcnt;
    mphase   = 0;
    mcnt     = 0;
    txd_flag = 1'b1;
    forever begin
      @(posedge clk50M);
      #1;
      if (!rst_n) begin
        txd_flag = 1'b1;
        mphase   = 0;
        mcnt     = 0;
      end else begin
        case (mphase)
          0: if (txd_cmd && !never_drop) begin mphase = 1; mcnt = 0; end
          1: begin
            mcnt++;
            if (mcnt == 2) begin txd_flag = 1'b0; mphase = 2; mcnt = 0; end
          end
          default: begin
            mcnt++;
            if (mcnt == HOLD) begin txd_flag = 1'b1; mphase = 0; end
          end
        endcase
      end
    end
  end

  // Monitor: pops expectations whenever the DUT issues a cmd or an ack
  initial begin
    grant_exp_t g;
    ack_exp_t   a;
    int         cmd_cyc;
    logic       prev_cmd;
    logic       prev_ack;
    logic [7:0] cur_data;
    cmd_cyc  = 0;
    prev_cmd = 1'b0;
    prev_ack = 1'b0;
    cur_data = 8'h00;
    forever begin
      @(negedge clk50M);
      if (!rst_n) begin
        prev_cmd = 1'b0;
        prev_ack = 1'b0;
      end else begin
        if (prev_ack) check("busy_after_ack", 32'(busy), 32'(0));
        if (txd_cmd) begin
          check("cmd_one_cycle", 32'(prev_cmd), 32'(0));
          if (exp_g.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_cmd: got grant_id %0d data 0x%0h, expected none", grant_id, txd_data);
          end else begin
            g = exp_g.pop_front();
            check("grant_id", 32'(grant_id), 32'(g.id));
            check("txd_data", 32'(txd_data), 32'(g.data));
            check("busy_at_cmd", 32'(busy), 32'(1));
            cur_data = g.data;
          end
          cmd_cyc = cyc;
        end
        if (ack != '0) begin
          if (exp_a.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ack: got ack 0x%0h, expected none", ack);
          end else begin
            a = exp_a.pop_front();
            check("ack_mask", 32'(ack), 32'(a.mask));
            check("ack_latency", 32'(cyc - cmd_cyc), 32'(a.lat));
            check("timeout_err", 32'(timeout_err), 32'(a.terr));
            check("data_stable", 32'(txd_data), 32'(cur_data));
          end
        end
        prev_cmd = txd_cmd;
        prev_ack = (ack != '0);
      end
    end
  end

  // Requester agent: drops req[i] once its byte quota is acked
  task automatic run(input int n_acks, input int budget, input logic [N-1:0] late_mask,
                     input int late_at, input logic drop_on_grant);
    int got;
    int t;
    got = 0;
    t   = 0;
    while (got < n_acks && t < budget) begin
      @(negedge clk50M);
      t++;
      if (t == late_at) req = req | late_mask;
      if (drop_on_grant && txd_cmd) begin
        for (int i = 0; i < int'(N); i++) if (grant_id == 3'(i)) req[i] = 1'b0;
      end
      for (int i = 0; i < int'(N); i++) begin
        if (ack[i]) begin
          got++;
          if (remaining[i] > 0) remaining[i]--;
          if (remaining[i] == 0) req[i] = 1'b0;
        end
      end
    end
    check("acks_within_budget", 32'(got), 32'(n_acks));
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk50M);
  endtask

  initial begin
    #(20 * 60000);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int waited;
    rst_n    = 1'b0;
    req      = '0;
    req_data = '0;
    for (int i = 0; i < int'(N); i++) remaining[i] = 0;
    idle(3);
    check("rst_ack", 32'(ack), 32'(0));
    check("rst_grant_id", 32'(grant_id), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_timeout_err", 32'(timeout_err), 32'(0));
    check("rst_txd_cmd", 32'(txd_cmd), 32'(0));
    check("rst_txd_data", 32'(txd_data), 32'(0));
    rst_n = 1'b1;
    idle(2);

    // Fairness: all four held for two bytes each, order 0,1,2,3,0,1,2,3
    req_data = 32'h13121110;
    for (int i = 0; i < int'(N); i++) remaining[i] = 2;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < int'(N); i++) begin
        push_grant(i, 8'h10 + 8'(i));
        push_ack(4'(1 << i), 1'b0, LAT_OK);
      end
    end
    req = 4'b1111;
    run(8, 400, 4'b0000, 0, 1'b0);
    idle(4);

    // Single request from requester 2
    req_data     = 32'h005A0000;
    remaining[2] = 1;
    push_grant(2, 8'h5A);
    push_ack(4'b0100, 1'b0, LAT_OK);
    req = 4'b0100;
    run(1, 100, 4'b0000, 0, 1'b0);
    idle(4);

    // Late entrant: requester 3 joins while requester 1 is mid-transfer
    req_data     = 32'h23002100;
    remaining[1] = 2;
    remaining[3] = 1;
    push_grant(1, 8'h21);
    push_ack(4'b0010, 1'b0, LAT_OK);
    push_grant(3, 8'h23);
    push_ack(4'b1000, 1'b0, LAT_OK);
    push_grant(1, 8'h21);
    push_ack(4'b0010, 1'b0, LAT_OK);
    req = 4'b0010;
    run(3, 300, 4'b1000, 8, 1'b0);
    idle(4);

    // Timeout: flag never falls, then next requester served normally
    never_drop   = 1'b1;
    req_data     = 32'h00000044;
    remaining[0] = 1;
    push_grant(0, 8'h44);
    push_ack(4'b0001, 1'b1, LAT_TO);
    req = 4'b0001;
    run(1, 100, 4'b0000, 0, 1'b0);
    never_drop = 1'b0;
    idle(4);
    req_data     = 32'h00660000;
    remaining[2] = 1;
    push_grant(2, 8'h66);
    push_ack(4'b0100, 1'b1, LAT_OK);
    req = 4'b0100;
    run(1, 100, 4'b0000, 0, 1'b0);
    idle(4);

    // Drop after grant: transfer still completes with one ack, no regrant
    req_data     = 32'h77000000;
    remaining[3] = 1;
    push_grant(3, 8'h77);
    push_ack(4'b1000, 1'b1, LAT_OK);
    req = 4'b1000;
    run(1, 100, 4'b0000, 0, 1'b1);
    idle(8);

    // Reset during WAIT_DONE: outputs clear at once, no ack for aborted byte
    req_data     = 32'h00003100;
    remaining[1] = 1;
    push_grant(1, 8'h31);
    req    = 4'b0010;
    waited = 0;
    do begin
      @(negedge clk50M);
      waited++;
    end while (!txd_cmd && waited < 20);
    check("reset_test_cmd_seen", 32'(txd_cmd), 32'(1));
    idle(6);
    check("mid_transfer_busy", 32'(busy), 32'(1));
    rst_n = 1'b0;
    req   = '0;
    for (int i = 0; i < int'(N); i++) remaining[i] = 0;
    #1;
    check("async_rst_ack", 32'(ack), 32'(0));
    check("async_rst_busy", 32'(busy), 32'(0));
    check("async_rst_txd_cmd", 32'(txd_cmd), 32'(0));
    check("async_rst_txd_data", 32'(txd_data), 32'(0));
    check("async_rst_grant_id", 32'(grant_id), 32'(0));
    check("async_rst_timeout_err", 32'(timeout_err), 32'(0));
    idle(2);
    rst_n = 1'b1;
    idle(2);

    // After reset, requester 0 wins a 4-way contention
    req_data = 32'h83828180;
    for (int i = 0; i < int'(N); i++) begin
      remaining[i] = 1;
      push_grant(i, 8'h80 + 8'(i));
      push_ack(4'(1 << i), 1'b0, LAT_OK);
    end
    req = 4'b1111;
    run(4, 300, 4'b0000, 0, 1'b0);
    idle(10);

    check("grant_queue_drained", 32'(exp_g.size()), 32'(0));
    check("ack_queue_drained", 32'(exp_a.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
